// File: rtl/sdram_arb.sv
// Two-master (CPU / DMA) round-robin front end for the SDRAM controller.
// Each grant becomes one fixed-length controller machine cycle with a one-clock ack.
module sdram_arb #(
  parameter int CYCLE_LEN = 16,
  parameter int RD_SAMPLE = 9
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [23:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic        as,
  output logic        csn,
  output logic        nwr,
  output logic [23:0] ad,
  output logic [15:0] din,
  input  logic [15:0] sd_dout
);

  typedef enum logic [1:0] {IDLE, SLOT, ACK} state_t;

  localparam logic [4:0] LAST   = 5'(CYCLE_LEN - 1);
  localparam logic [4:0] SAMPLE = 5'(RD_SAMPLE);

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        as_q, csn_q, nwr_q;
  logic [23:0] ad_q;
  logic [15:0] din_q;
  logic [15:0] cpu_rdata_q, dma_rdata_q;
  logic        cpu_ack_q, dma_ack_q;
  logic        grant_q;       // 0 = CPU, 1 = DMA
  logic        last_grant_q;
  logic        grant_d;

  // DMA wins only when alone, or on a tie when the CPU had the previous slot.
  assign grant_d = dma_req & (~cpu_req | ~last_grant_q);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      as_q         <= 1'b0;
      csn_q        <= 1'b1;
      nwr_q        <= 1'b1;
      ad_q         <= '0;
      din_q        <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req | dma_req) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            ad_q         <= grant_d ? dma_addr : cpu_addr;
            nwr_q        <= ~(grant_d ? dma_wr : cpu_wr);
            din_q        <= grant_d ? dma_wdata : cpu_wdata;
            csn_q        <= 1'b0;
            as_q         <= 1'b1;
            cnt_q        <= '0;
            state_q      <= SLOT;
          end
        end
        SLOT: begin
          as_q  <= 1'b0;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == SAMPLE && nwr_q) begin
            if (grant_q) dma_rdata_q <= sd_dout;
            else         cpu_rdata_q <= sd_dout;
          end
          if (cnt_q == LAST) begin
            csn_q     <= 1'b1;
            nwr_q     <= 1'b1;
            cpu_ack_q <= ~grant_q;
            dma_ack_q <= grant_q;
            state_q   <= ACK;
          end
        end
        ACK: begin
          // Requests are not sampled here, so the just-acked master cannot retrigger early.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign as        = as_q;
  assign csn       = csn_q;
  assign nwr       = nwr_q;
  assign ad        = ad_q;
  assign din       = din_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: expected slots queued at stimulus time, checked at as/ack.
module tb_sdram_arb;

  localparam int CYCLE_LEN = 16;
  localparam int RD_SAMPLE = 9;

  typedef struct packed {
    logic        m;       // 0 = CPU, 1 = DMA
    logic        wr;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_wr = 1'b0;
  logic [23:0] dma_addr = '0;
  logic [15:0] dma_wdata = '0;
  logic [15:0] dma_rdata;
  logic        dma_ack;
  logic        as, csn, nwr;
  logic [23:0] ad;
  logic [15:0] din;
  logic [15:0] sd_dout = '0;

  txn_t        exp_q[$];
  txn_t        cur;
  logic [15:0] exp_cpu_rd = '0, exp_dma_rd = '0;
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0, off = 0, prev_as = 0;
  bit          in_slot = 0, slot_bad = 0, prev_valid = 0, chk_space = 0;

  sdram_arb #(.CYCLE_LEN(CYCLE_LEN), .RD_SAMPLE(RD_SAMPLE)) dut (
    .clk_in(clk_in), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .as(as), .csn(csn), .nwr(nwr), .ad(ad), .din(din), .sd_dout(sd_dout)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard / sd_dout model ----------------
  always @(negedge clk_in) begin
    cyc++;
    if (rst) begin
      in_slot    = 0;
      prev_valid = 0;
    end else if (as) begin
      if (exp_q.size() == 0) check("as_unexpected", 1, 0);
      else begin
        cur = exp_q[0];
        check("as_ad", ad, cur.addr);
        check("as_nwr", nwr, !cur.wr);
        check("as_din", din, cur.wdata);
        check("as_csn", csn, 0);
      end
      if (chk_space && prev_valid) check("as_spacing", cyc - prev_as, CYCLE_LEN + 2);
      prev_as = cyc; prev_valid = 1;
      in_slot = 1; off = 0; slot_bad = 0;
    end else if (in_slot) begin
      off++;
      if (off < CYCLE_LEN) begin
        if (as !== 1'b0 || csn !== 1'b0 || ad !== cur.addr || nwr !== !cur.wr ||
            din !== cur.wdata || cpu_ack !== 1'b0 || dma_ack !== 1'b0) slot_bad = 1;
      end else begin
        check("slot_stable", slot_bad, 0);
        check("ack_sel", {cpu_ack, dma_ack}, cur.m ? 2'b01 : 2'b10);
        check("ack_csn", csn, 1);
        check("ack_nwr", nwr, 1);
        if (!cur.wr) begin
          if (cur.m) exp_dma_rd = cur.rdata;
          else       exp_cpu_rd = cur.rdata;
        end
        check("cpu_rdata", cpu_rdata, exp_cpu_rd);
        check("dma_rdata", dma_rdata, exp_dma_rd);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        in_slot = 0;
      end
    end else if (cpu_ack || dma_ack) begin
      check("stray_ack", {cpu_ack, dma_ack}, 2'b00);
    end
    // Only the RD_SAMPLE clock carries the slot's read word; neighbours carry different values.
    if (in_slot) sd_dout = (off == RD_SAMPLE) ? cur.rdata : (cur.rdata ^ 16'hFFFF ^ 16'(off));
    else         sd_dout = 16'h0000;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit m, input bit wr, input logic [23:0] a, input logic [15:0] d);
    if (!m) begin cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; end
    else    begin dma_wr = wr; dma_addr = a; dma_wdata = d; dma_req = 1'b1; end
  endtask

  task automatic release_req(input bit m);
    if (!m) cpu_req = 1'b0;
    else    dma_req = 1'b0;
  endtask

  task automatic wait_ack(input bit m);
    int n = 0;
    bit got = 0;
    while (!got && n < 300) begin
      @(negedge clk_in);
      n++;
      got = m ? dma_ack : cpu_ack;
    end
    if (!got) check(m ? "dma_ack_timeout" : "cpu_ack_timeout", 0, 1);
  endtask

  task automatic push(input bit m, input bit wr, input logic [23:0] a,
                      input logic [15:0] d, input logic [15:0] rd);
    txn_t t;
    t.m = m; t.wr = wr; t.addr = a; t.wdata = d; t.rdata = rd;
    exp_q.push_back(t);
  endtask

  task automatic single(input bit m, input bit wr, input logic [23:0] a,
                        input logic [15:0] d, input logic [15:0] rd);
    push(m, wr, a, d, rd);
    drive(m, wr, a, d);
    wait_ack(m);
    release_req(m);
    repeat (2) @(negedge clk_in);
  endtask

  task automatic pulse_reset;
    @(negedge clk_in);
    #2 rst = 1'b1;
    exp_cpu_rd = '0; exp_dma_rd = '0;
    repeat (2) @(negedge clk_in);
    #2 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  req_cyc, ack_cyc, n;
    bit  m, wr;
    logic [23:0] a;
    logic [15:0] d, rd;

    repeat (3) @(negedge clk_in);
    check("rst_as", as, 0);
    check("rst_csn", csn, 1);
    check("rst_nwr", nwr, 1);
    check("rst_ad", ad, 0);
    check("rst_din", din, 0);
    check("rst_acks", {cpu_ack, dma_ack}, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // CPU read, DMA idle
    single(0, 0, 24'h012345, 16'h0000, 16'hBEEF);
    // CPU write: rdata must stay at 0xBEEF
    single(0, 1, 24'h00000A, 16'h1234, 16'h0000);

    // Simultaneous requests from reset: CPU, DMA, CPU, DMA, spaced CYCLE_LEN+2
    pulse_reset();
    @(negedge clk_in);
    push(0, 0, 24'h100000, 16'h1111, 16'hC0C0);
    push(1, 1, 24'h200000, 16'h2222, 16'h0000);
    push(0, 0, 24'h100001, 16'h3333, 16'hC1C1);
    push(1, 0, 24'h200001, 16'h4444, 16'hD1D1);
    chk_space = 1;
    fork
      begin
        drive(0, 0, 24'h100000, 16'h1111); wait_ack(0);
        drive(0, 0, 24'h100001, 16'h3333); wait_ack(0);
        release_req(0);
      end
      begin
        drive(1, 1, 24'h200000, 16'h2222); wait_ack(1);
        drive(1, 0, 24'h200001, 16'h4444); wait_ack(1);
        release_req(1);
      end
    join
    chk_space = 0;
    repeat (2) @(negedge clk_in);

    // DMA streaming, CPU arrives mid-slot and takes the very next slot
    push(1, 0, 24'h300000, 16'h5555, 16'hD2D2);
    push(0, 0, 24'h400000, 16'h6666, 16'hC2C2);
    push(1, 1, 24'h300001, 16'h7777, 16'h0000);
    fork
      begin
        drive(1, 0, 24'h300000, 16'h5555); wait_ack(1);
        drive(1, 1, 24'h300001, 16'h7777); wait_ack(1);
        release_req(1);
      end
      begin
        n = 0;
        do begin @(negedge clk_in); n++; end while (as !== 1'b1 && n < 50);
        check("dma_slot_start", as, 1);
        repeat (5) @(negedge clk_in);
        req_cyc = cyc;
        drive(0, 0, 24'h400000, 16'h6666); wait_ack(0);
        ack_cyc = cyc;
        release_req(0);
        check("cpu_latency_ok", (ack_cyc - req_cyc) <= 2 * (CYCLE_LEN + 2), 1);
      end
    join
    repeat (2) @(negedge clk_in);

    // Reset at cnt 5 of a CPU read: outputs clear at once, held req restarts
    push(0, 0, 24'h0ABCDE, 16'h8888, 16'hA5A5);
    drive(0, 0, 24'h0ABCDE, 16'h8888);
    n = 0;
    do begin @(negedge clk_in); #1; n++; end while (!(in_slot && off == 5) && n < 60);
    check("reached_cnt5", off, 5);
    #1 rst = 1'b1;
    #1;
    exp_cpu_rd = '0; exp_dma_rd = '0;
    check("midrst_as", as, 0);
    check("midrst_csn", csn, 1);
    check("midrst_acks", {cpu_ack, dma_ack}, 0);
    check("midrst_cpu_rdata", cpu_rdata, 0);
    check("midrst_dma_rdata", dma_rdata, 0);
    repeat (2) @(negedge clk_in);
    check("rst_held_no_ack", {cpu_ack, dma_ack}, 0);
    #2 rst = 1'b0;
    wait_ack(0);
    release_req(0);
    repeat (2) @(negedge clk_in);

    // Random single-master traffic
    for (int i = 0; i < 8; i++) begin
      m  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 24'($urandom_range(0, 32'h00FF_FFFF));
      d  = 16'($urandom_range(0, 16'hFFFF));
      rd = 16'($urandom_range(1, 16'hFFFF));
      single(m, wr, a, d, rd);
    end

    repeat (4) @(negedge clk_in);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
